adc_par_capture: RTL and testbench
==================================

# adc_par_capture

Parametrised parallel-bus capture engine for AD7606-class simultaneous-sampling ADCs. It paces conversions from a programmable sample-rate divider, drives CONVST A–D, and tracks BUSY. It then reads NUM_CH words over the 16-bit DB bus with RD_N/CS_N strobes and buffers the enabled channels in an internal FIFO that feeds the SPI output path over a valid/ready stream. It replaces the fixed 8-channel, single-rate readout in the current ADC driver top level. It adds a channel mask, overrun and timeout detection, and a post-reset ADC reset pulse.

## Interface
- NUM_CH, 8: channels read per frame (1–8)
- DATA_W, 16: DB width
- SAMPLE_DIV, 2700: clocks between conversion triggers (≥ 64)
- CONV_PULSE, 2: CONVST low width, clocks
- RD_LOW, 2 / RD_HIGH, 2: RD_N low/high widths, clocks (≥1 each)
- BUSY_TIMEOUT, 256: clocks allowed for BUSY to rise and then fall
- FIFO_DEPTH, 16: entries, power of two
- ADC_RST_CYCLES, 4: adc_rst high width after reset release
- CLOCK_27M  in  1  system clock
- rst  in  1  synchronous, active-low reset
- enable  in  1  run conversions while high
- ch_mask  in  NUM_CH  bit i=1 → channel i pushed to FIFO
- clr_flags  in  1  one-cycle pulse, clears sticky flags
- BUSY  in  1  ADC busy, asynchronous
- DB  in  DATA_W  ADC data bus
- convst_A..convst_D  out  1 each  conversion start, idle high, all driven identically
- RD_N, ADC_CS_N  out  1  read strobe and chip select, active low
- adc_rst  out  1  ADC reset, active high
- m_valid  out  1 / m_ready  in  1  output stream handshake
- m_data  out  DATA_W  sample
- m_ch  out  $clog2(NUM_CH) (min 1)  channel index
- m_sof  out  1  first enabled channel of a frame
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow, overrun, timeout_err  out  1  sticky error flags

## Operation
- Reset (rst=0 at a clock edge) sets outputs as follows: convst_*=1, RD_N=1, ADC_CS_N=1, m_valid=0, fifo_level=0, all flags=0. The FSM goes to ST_ADCRST and the divider clears. adc_rst is high from the edge that releases reset through ADC_RST_CYCLES clocks, then low. The FSM then moves to IDLE.
- BUSY passes through a 2-flop synchroniser, and only busy_s is used.
- Divider: counts 0..SAMPLE_DIV-1 while enable=1 and holds at 0 while enable=0. It issues a tick when the count wraps to 0.
- FSM states and transitions:
  - IDLE: on tick, go to CONV.
  - CONV: convst_* low for CONV_PULSE clocks, then go to WAIT_HI.
  - WAIT_HI: when busy_s=1, go to WAIT_LO.
  - WAIT_LO: when busy_s=0, set ch=0 and go to RD_L.
  - RD_L: ADC_CS_N=0 and RD_N=0 for RD_LOW clocks. DB is registered on the last of those clocks.
  - RD_H: RD_N=1 for RD_HIGH clocks. On entry to RD_H, the registered word for channel ch is pushed if ch_mask[ch]=1. If ch==NUM_CH-1, go to IDLE with ADC_CS_N=1. Otherwise ch++ and go to RD_L.
- WAIT_HI and WAIT_LO share a timeout counter that is cleared on entry to WAIT_HI. When it reaches BUSY_TIMEOUT, the FSM sets timeout_err, goes to IDLE, and pushes nothing for that frame.
- A tick that arrives while the FSM is not in IDLE sets overrun. That trigger is dropped, not queued.
- enable=0 stops new triggers only. A frame in progress completes.
- ch_mask is sampled on entry to CONV and held for the whole frame.
- m_sof is set on the first push of a frame. If ch_mask=0, the frame is read but nothing is pushed.
- FIFO is first-word-fall-through:
  - m_valid = (level≠0). m_data, m_ch and m_sof hold steady while m_valid=1 and m_ready=0.
  - A pop happens when m_valid and m_ready are both high.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle. Otherwise the word is dropped and overflow is set.
  - A simultaneous push and pop leaves level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: clr_flags clears them. If clr_flags coincides with a new error event, the flag stays set.

## Timing
- Trigger latency: convst_* falls on the clock after the tick.
- BUSY response: busy_s lags BUSY by 2 clocks.
- First read: RD_N falls 1 clock after WAIT_LO sees busy_s=0.
- Per-channel read time is RD_LOW+RD_HIGH clocks. The first push lands 1 clock after the first DB sample.
- Push to output: a pushed word is visible on m_valid the next clock.
- Frame length (no timeout) is CONV_PULSE + busy + 2 sync + NUM_CH·(RD_LOW+RD_HIGH) + 2 clocks. It must be less than SAMPLE_DIV, otherwise overrun is set.
- Reset mid-frame: on the next clock ADC_CS_N=1, RD_N=1, convst_*=1, and the FIFO is emptied. The adc_rst sequence then repeats.

## Test plan
- Reset: hold rst=0 for 3 clocks, release → adc_rst=1 for exactly 4 clocks; convst_*/RD_N/ADC_CS_N=1; m_valid=0; fifo_level=0; flags 0.
- Full frame: NUM_CH=8, ch_mask=0xFF, BUSY high 30 clocks after CONVST, DB=ch·0x1111 during RD_N low → 8 words 0x0000..0x7777, m_ch 0..7, m_sof only on ch 0; 8 RD_N pulses each 2 low / 2 high.
- Masking: ch_mask=0x05 → per frame exactly 2 words, ch0 (m_sof=1) then ch2 (m_sof=0); still 8 RD_N pulses.
- Overflow: FIFO_DEPTH=16, m_ready=0, mask 0xFF, 3 frames → fifo_level=16, overflow=1, first 16 words intact; clr_flags → overflow=0.
- Timeout and overrun: BUSY stuck 0 → timeout_err=1 after 256 clocks in WAIT_HI, no pushes. Separately, SAMPLE_DIV=64 with BUSY high 60 clocks → overrun=1.
- Mid-frame events: enable dropped during the 3rd read → frame finishes (8 reads), then no further CONVST. rst=0 during a read → next clock RD_N=1, ADC_CS_N=1, fifo_level=0.

Source files
------------

// File: rtl/adc_par_capture_if.sv
// Output sample stream of adc_par_capture (valid/ready, first-word-fall-through).
//   master: m_valid, m_data, m_ch, m_sof driven by the capture engine; m_ready in
//   slave : the consumer (SPI output path) side
interface adc_par_capture_if #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 3
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CH_W-1:0]   m_ch;
  logic              m_sof;

  modport master (output m_valid, m_data, m_ch, m_sof, input m_ready);
  modport slave  (input m_valid, m_data, m_ch, m_sof, output m_ready);
endinterface

// File: rtl/adc_par_capture.sv
// Parallel-bus capture engine for AD7606-class simultaneous-sampling ADCs.
// Paces conversions from a sample-rate divider, pulses CONVST A-D, waits out
// BUSY, reads NUM_CH words over DB with RD_N/ADC_CS_N and queues the enabled
// channels in a FWFT FIFO presented on the stream interface m.
// Ports:
//   CLOCK_27M, rst (sync, active low)      clock / reset
//   enable, ch_mask, clr_flags             control
//   BUSY (async), DB                       ADC inputs
//   convst_A..D, RD_N, ADC_CS_N, adc_rst   ADC controls
//   m (master)                             sample stream {data, ch, sof}
//   fifo_level                             FIFO occupancy
//   overflow, overrun, timeout_err         sticky error flags
module adc_par_capture #(
  parameter int NUM_CH         = 8,
  parameter int DATA_W         = 16,
  parameter int SAMPLE_DIV     = 2700,
  parameter int CONV_PULSE     = 2,
  parameter int RD_LOW         = 2,
  parameter int RD_HIGH        = 2,
  parameter int BUSY_TIMEOUT   = 256,
  parameter int FIFO_DEPTH     = 16,
  parameter int ADC_RST_CYCLES = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLOCK_27M,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              clr_flags,
  input  logic              BUSY,
  input  logic [DATA_W-1:0] DB,
  output logic              convst_A,
  output logic              convst_B,
  output logic              convst_C,
  output logic              convst_D,
  output logic              RD_N,
  output logic              ADC_CS_N,
  output logic              adc_rst,
  adc_par_capture_if.master m,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              overrun,
  output logic              timeout_err
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(BUSY_TIMEOUT, ADC_RST_CYCLES),
                                max2(CONV_PULSE, max2(RD_LOW, RD_HIGH)));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(SAMPLE_DIV);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENT_W   = DATA_W + CH_W + 1;

  typedef enum logic [2:0] {
    ST_ADCRST, ST_IDLE, ST_CONV, ST_WAIT_HI, ST_WAIT_LO, ST_RD_L, ST_RD_H
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               adc_rst_q, adc_rst_d;
  logic               sof_pend_q;
  logic               conv_n_q, rd_n_q, cs_n_q;
  logic               busy_m_q, busy_s_q;
  logic [DIV_W-1:0]   div_q;
  logic               tick, tmo_evt, push_req, push_ok, pop, full;
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [LVL_W-1:0]   lvl_q;
  logic               ovf_q, ovr_q, tmo_q;
  logic [ENT_W-1:0]   mem [FIFO_DEPTH];

  assign tick = enable && (div_q == DIV_W'(SAMPLE_DIV - 1));

  // -------------------------------------------------------------- FSM comb
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    mask_d    = mask_q;
    data_d    = data_q;
    adc_rst_d = 1'b0;
    tmo_evt   = 1'b0;
    case (state_q)
      ST_ADCRST:
        if (cnt_q == CNT_W'(ADC_RST_CYCLES)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          adc_rst_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end
      ST_IDLE:
        if (tick) begin
          state_d = ST_CONV;
          cnt_d   = '0;
          mask_d  = ch_mask;
        end
      ST_CONV:
        if (cnt_q == CNT_W'(CONV_PULSE - 1)) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      // cnt keeps running across WAIT_HI -> WAIT_LO so the budget covers both
      ST_WAIT_HI:
        if (busy_s_q) begin
          state_d = ST_WAIT_LO;
          cnt_d   = cnt_q + 1'b1;
        end else if (cnt_q >= CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          tmo_evt = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      ST_WAIT_LO:
        if (!busy_s_q) begin
          state_d = ST_RD_L;
          cnt_d   = '0;
          ch_d    = '0;
        end else if (cnt_q >= CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          tmo_evt = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      ST_RD_L:
        if (cnt_q == CNT_W'(RD_LOW - 1)) begin
          data_d  = DB;
          state_d = ST_RD_H;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      ST_RD_H:
        if (cnt_q == CNT_W'(RD_HIGH - 1)) begin
          cnt_d = '0;
          if (ch_q == CH_W'(NUM_CH - 1)) state_d = ST_IDLE;
          else begin
            ch_d    = ch_q + 1'b1;
            state_d = ST_RD_L;
          end
        end else cnt_d = cnt_q + 1'b1;
      default: state_d = ST_ADCRST;
    endcase
  end

  // First cycle of RD_H carries the word just latched from DB.
  assign push_req = (state_q == ST_RD_H) && (cnt_q == '0) && mask_q[ch_q];
  assign full     = (lvl_q == LVL_W'(FIFO_DEPTH));
  assign pop      = (lvl_q != '0) && m.m_ready;
  assign push_ok  = push_req && (!full || pop);

  // ------------------------------------------------------------- registers
  always_ff @(posedge CLOCK_27M) begin
    if (!rst) begin
      state_q    <= ST_ADCRST;
      cnt_q      <= '0;
      ch_q       <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      adc_rst_q  <= 1'b0;
      sof_pend_q <= 1'b0;
      conv_n_q   <= 1'b1;
      rd_n_q     <= 1'b1;
      cs_n_q     <= 1'b1;
      busy_m_q   <= 1'b0;
      busy_s_q   <= 1'b0;
      div_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      lvl_q      <= '0;
      ovf_q      <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      adc_rst_q <= adc_rst_d;
      // strobes registered from next state so the ADC pins never glitch
      conv_n_q  <= (state_d != ST_CONV);
      rd_n_q    <= (state_d != ST_RD_L);
      cs_n_q    <= !(state_d inside {ST_RD_L, ST_RD_H});
      busy_m_q  <= BUSY;
      busy_s_q  <= busy_m_q;

      if (!enable || div_q == DIV_W'(SAMPLE_DIV - 1)) div_q <= '0;
      else                                            div_q <= div_q + 1'b1;

      if (state_q == ST_IDLE && tick) sof_pend_q <= 1'b1;
      else if (push_req)              sof_pend_q <= 1'b0;

      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (push_ok && !pop)      lvl_q <= lvl_q + 1'b1;
      else if (!push_ok && pop) lvl_q <= lvl_q - 1'b1;

      // a new event wins over a coincident clear
      ovf_q <= (ovf_q & ~clr_flags) | (push_req && full && !pop);
      ovr_q <= (ovr_q & ~clr_flags) | (tick && state_q != ST_IDLE);
      tmo_q <= (tmo_q & ~clr_flags) | tmo_evt;
    end
  end

  always_ff @(posedge CLOCK_27M) begin
    if (push_ok) mem[wr_q] <= {sof_pend_q, ch_q, data_q};
  end

  assign {m.m_sof, m.m_ch, m.m_data} = mem[rd_q];
  assign m.m_valid   = (lvl_q != '0);
  assign fifo_level  = lvl_q;
  assign convst_A    = conv_n_q;
  assign convst_B    = conv_n_q;
  assign convst_C    = conv_n_q;
  assign convst_D    = conv_n_q;
  assign RD_N        = rd_n_q;
  assign ADC_CS_N    = cs_n_q;
  assign adc_rst     = adc_rst_q;
  assign overflow    = ovf_q;
  assign overrun     = ovr_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_adc_par_capture.sv
// Bench for adc_par_capture: behavioural AD7606 model (BUSY, DB per RD_N pulse)
// builds the expected stream per frame from the mask; a monitor collects popped
// words; each test task compares inline.
module tb_adc_par_capture;
  localparam int NUM_CH = 8, DATA_W = 16, CH_W = 3, DIV = 400, FDEPTH = 16;
  localparam int CONV_PULSE = 2, BUSY_TIMEOUT = 256, RD_LOW = 2, RD_HIGH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, enable = 1'b0, clr_flags = 1'b0, BUSY = 1'b0, rdy = 1'b0;
  logic ovr_en = 1'b0, ovr_busy = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [DATA_W-1:0] DB = '0;
  logic convst_A, convst_B, convst_C, convst_D, RD_N, ADC_CS_N, adc_rst;
  logic [4:0] fifo_level;
  logic overflow, overrun, timeout_err;
  logic o_cA, o_cB, o_cC, o_cD, o_rd, o_cs, o_arst, o_ovf, o_ovr, o_tmo;
  logic [4:0] o_lvl;

  adc_par_capture_if #(.DATA_W(DATA_W), .CH_W(CH_W)) mif ();
  adc_par_capture_if #(.DATA_W(DATA_W), .CH_W(CH_W)) oif ();
  assign mif.m_ready = rdy;
  assign oif.m_ready = 1'b1;

  adc_par_capture #(.SAMPLE_DIV(DIV)) u_dut (
    .CLOCK_27M(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .clr_flags(clr_flags), .BUSY(BUSY), .DB(DB),
    .convst_A(convst_A), .convst_B(convst_B), .convst_C(convst_C), .convst_D(convst_D),
    .RD_N(RD_N), .ADC_CS_N(ADC_CS_N), .adc_rst(adc_rst), .m(mif.master),
    .fifo_level(fifo_level), .overflow(overflow), .overrun(overrun),
    .timeout_err(timeout_err));

  // short-period instance used only to provoke overrun
  adc_par_capture #(.SAMPLE_DIV(64)) u_ovr (
    .CLOCK_27M(clk), .rst(rst), .enable(ovr_en), .ch_mask(ch_mask),
    .clr_flags(clr_flags), .BUSY(ovr_busy), .DB(DB),
    .convst_A(o_cA), .convst_B(o_cB), .convst_C(o_cC), .convst_D(o_cD),
    .RD_N(o_rd), .ADC_CS_N(o_cs), .adc_rst(o_arst), .m(oif.master),
    .fifo_level(o_lvl), .overflow(o_ovf), .overrun(o_ovr), .timeout_err(o_tmo));

  int n_tests = 0, n_fail = 0;

  // ------------------------------------------------------------ ADC model
  logic [DATA_W-1:0] words [NUM_CH];
  logic [19:0] exp_q[$], got_q[$];
  bit fixed_pat = 1'b0, busy_stuck = 1'b0;
  int busy_len = 30, busy_wait = 0, busy_left = 0;
  int conv_count = 0, rd_frame = 0, rd_idx = 0, lo_w = 0, hi_w = 0;
  int width_bad = 0, conv_skew = 0, conv_w = 0, last_conv_w = 0;
  logic prev_conv = 1'b1, prev_rd = 1'b1, o_prev = 1'b1;
  int ovr_left = 0;

  always @(negedge clk) begin
    if (convst_A !== convst_B || convst_A !== convst_C || convst_A !== convst_D) conv_skew++;
    if (busy_wait > 0) begin
      busy_wait--;
      if (busy_wait == 0 && !busy_stuck) begin BUSY = 1'b1; busy_left = busy_len; end
    end else if (BUSY) begin
      busy_left--;
      if (busy_left <= 0) BUSY = 1'b0;
    end
    if (prev_conv === 1'b1 && convst_A === 1'b0) begin
      bit first;
      conv_count++; rd_frame = 0; rd_idx = 0; busy_wait = 1; conv_w = 0;
      first = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        words[i] = fixed_pat ? DATA_W'(i * 16'h1111) : DATA_W'($urandom);
        if (!busy_stuck && ch_mask[i]) begin
          exp_q.push_back({first, CH_W'(i), words[i]});
          first = 1'b0;
        end
      end
    end
    if (convst_A === 1'b0) conv_w++;
    if (prev_conv === 1'b0 && convst_A === 1'b1) last_conv_w = conv_w;
    if (prev_rd === 1'b1 && RD_N === 1'b0) begin
      if (rd_frame > 0 && hi_w != RD_HIGH) width_bad++;
      if (rd_idx < NUM_CH) DB = words[rd_idx];
      lo_w = 0; rd_frame++;
    end
    if (prev_rd === 1'b0 && RD_N === 1'b1) begin
      if (lo_w != RD_LOW) width_bad++;
      rd_idx++; hi_w = 0;
    end
    if (RD_N === 1'b0) lo_w++; else hi_w++;
    prev_rd = RD_N;
    prev_conv = convst_A;
  end

  always @(negedge clk) begin
    if (o_prev === 1'b1 && o_cA === 1'b0) begin ovr_busy = 1'b1; ovr_left = 60; end
    else if (ovr_left > 0) begin
      ovr_left--;
      if (ovr_left == 0) ovr_busy = 1'b0;
    end
    o_prev = o_cA;
  end

  always @(negedge clk)
    if (mif.m_valid === 1'b1 && rdy === 1'b1) got_q.push_back({mif.m_sof, mif.m_ch, mif.m_data});

  // -------------------------------------------------------------- helpers
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_conv(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (conv_count >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rd(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (rd_frame >= target && ADC_CS_N === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic count_adc_rst(output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin cyc(1); if (adc_rst === 1'b1) n++; end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    int n;
    rst = 1'b0; enable = 1'b0; rdy = 1'b0;
    cyc(3);
    n_tests++;
    if ({convst_A, RD_N, ADC_CS_N} !== 3'b111) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 111", {convst_A, RD_N, ADC_CS_N});
    end
    n_tests++;
    if ({mif.m_valid, fifo_level, overflow, overrun, timeout_err} !== 9'd0) begin
      n_fail++; $display("FAIL reset_state: valid=%b lvl=%0d flags=%b%b%b want all 0",
                         mif.m_valid, fifo_level, overflow, overrun, timeout_err);
    end
    rst = 1'b1;
    count_adc_rst(n);
    n_tests++;
    if (n != 4) begin n_fail++; $display("FAIL reset_adc_rst_width: got %0d want 4", n); end
    n_tests++;
    if ({convst_A, RD_N, ADC_CS_N, adc_rst} !== 4'b1110) begin
      n_fail++; $display("FAIL reset_after: got %b want 1110", {convst_A, RD_N, ADC_CS_N, adc_rst});
    end
  endtask

  task automatic run_frame(input string name, input logic [NUM_CH-1:0] mask);
    bit ok;
    exp_q.delete(); got_q.delete();
    ch_mask = mask; rdy = 1'b1; enable = 1'b1;
    wait_conv(conv_count + 1, DIV + 50, ok);
    enable = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s_conv: no CONVST within budget", name); end
    wait_rd(NUM_CH, 400, ok);
    cyc(10);
    n_tests++;
    if (rd_frame != NUM_CH) begin n_fail++; $display("FAIL %s_rd_pulses: got %0d want %0d", name, rd_frame, NUM_CH); end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s_words: got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s_word%0d: got %h want %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_full_frame;
    fixed_pat = 1'b1; busy_len = 30; width_bad = 0; conv_skew = 0;
    run_frame("full_frame", 8'hFF);
    fixed_pat = 1'b0;
    n_tests++;
    if (width_bad != 0) begin n_fail++; $display("FAIL rd_widths: got %0d bad pulses want 0", width_bad); end
    n_tests++;
    if (last_conv_w != CONV_PULSE) begin n_fail++; $display("FAIL convst_width: got %0d want %0d", last_conv_w, CONV_PULSE); end
    n_tests++;
    if (conv_skew != 0) begin n_fail++; $display("FAIL convst_abcd: got %0d skewed samples want 0", conv_skew); end
  endtask

  task automatic test_mask;
    logic [NUM_CH-1:0] m;
    run_frame("mask05", 8'h05);
    for (int k = 0; k < 3; k++) begin
      m = NUM_CH'($urandom);
      busy_len = $urandom_range(5, 60);
      run_frame("mask_rand", m);
    end
    run_frame("mask00", 8'h00);
  endtask

  task automatic test_overflow;
    bit ok;
    exp_q.delete(); got_q.delete();
    ch_mask = 8'hFF; rdy = 1'b0; busy_len = 20; enable = 1'b1;
    wait_conv(conv_count + 3, 3 * DIV + 100, ok);
    enable = 1'b0;
    wait_rd(NUM_CH, 400, ok);
    cyc(10);
    n_tests++;
    if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
    n_tests++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    rdy = 1'b1;
    cyc(40);
    n_tests++;
    if (got_q.size() != FDEPTH) begin n_fail++; $display("FAIL ovf_drain: got %0d want 16", got_q.size()); end
    for (int i = 0; i < FDEPTH && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ovf_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    clr_flags = 1'b1; cyc(1); clr_flags = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_timeout;
    int k;
    bit seen;
    exp_q.delete(); got_q.delete();
    busy_stuck = 1'b1; ch_mask = 8'hFF; rdy = 1'b1; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < DIV + 50; i++) begin cyc(1); if (convst_A === 1'b0) begin seen = 1'b1; break; end end
    enable = 1'b0;
    k = 0;
    for (int i = 0; i < 400 && seen; i++) begin cyc(1); k++; if (timeout_err === 1'b1) break; end
    n_tests++;
    if (k != CONV_PULSE + BUSY_TIMEOUT) begin
      n_fail++; $display("FAIL timeout_latency: got %0d want %0d", k, CONV_PULSE + BUSY_TIMEOUT);
    end
    cyc(20);
    n_tests++;
    if (timeout_err !== 1'b1 || rd_frame != 0 || got_q.size() != 0 || fifo_level !== 5'd0) begin
      n_fail++; $display("FAIL timeout_nopush: err=%b rd=%0d words=%0d lvl=%0d want 1/0/0/0",
                         timeout_err, rd_frame, got_q.size(), fifo_level);
    end
    busy_stuck = 1'b0;
    clr_flags = 1'b1; cyc(1); clr_flags = 1'b0;
    n_tests++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_overrun;
    n_tests++;
    if (o_ovr !== 1'b0) begin n_fail++; $display("FAIL overrun_pre: got %b want 0", o_ovr); end
    ovr_en = 1'b1;
    for (int i = 0; i < 400; i++) begin cyc(1); if (o_ovr === 1'b1) break; end
    ovr_en = 1'b0;
    cyc(150);
    n_tests++;
    if (o_ovr !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", o_ovr); end
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_main: got %b want 0", overrun); end
    clr_flags = 1'b1; cyc(1); clr_flags = 1'b0;
    n_tests++;
    if (o_ovr !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", o_ovr); end
  endtask

  task automatic test_enable_midframe;
    bit ok;
    int c;
    exp_q.delete(); got_q.delete();
    ch_mask = NUM_CH'($urandom) | 8'h01; rdy = 1'b1; busy_len = 25; enable = 1'b1;
    wait_conv(conv_count + 1, DIV + 50, ok);
    for (int i = 0; i < 200; i++) begin cyc(1); if (rd_frame >= 3) break; end
    enable = 1'b0;
    wait_rd(NUM_CH, 400, ok);
    cyc(10);
    n_tests++;
    if (rd_frame != NUM_CH) begin n_fail++; $display("FAIL en_mid_reads: got %0d want 8", rd_frame); end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL en_mid_words: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL en_mid_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    c = conv_count;
    cyc(2 * DIV);
    n_tests++;
    if (conv_count != c) begin n_fail++; $display("FAIL en_mid_stop: got %0d frames want %0d", conv_count, c); end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    int n;
    exp_q.delete(); got_q.delete();
    ch_mask = 8'hFF; rdy = 1'b0; busy_len = 15; enable = 1'b1;
    wait_conv(conv_count + 1, DIV + 50, ok);
    enable = 1'b0;
    for (int i = 0; i < 200; i++) begin cyc(1); if (rd_frame >= 4 && RD_N === 1'b0) break; end
    n_tests++;
    if (fifo_level !== 5'd3) begin n_fail++; $display("FAIL rst_mid_level_pre: got %0d want 3", fifo_level); end
    rst = 1'b0;
    cyc(1);
    n_tests++;
    if ({RD_N, ADC_CS_N, convst_A, mif.m_valid, fifo_level} !== {4'b1110, 5'd0}) begin
      n_fail++; $display("FAIL rst_mid_outputs: rd=%b cs=%b cv=%b valid=%b lvl=%0d want 1/1/1/0/0",
                         RD_N, ADC_CS_N, convst_A, mif.m_valid, fifo_level);
    end
    rst = 1'b1;
    count_adc_rst(n);
    n_tests++;
    if (n != 4) begin n_fail++; $display("FAIL rst_mid_adc_rst: got %0d want 4", n); end
    rdy = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_mask();
    test_overflow();
    test_timeout();
    test_overrun();
    test_enable_midframe();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
